alu_mul_seq: RTL and testbench



---
 rtl/alu_mul_seq_pkg.sv | 14 +
 rtl/alu_mul_seq_alu16.sv | 24 ++
 rtl/alu_mul_seq.sv | 131 +++++++++++++
 tb/tb_alu_mul_seq.sv | 131 +++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared opcodes and state encoding for the shift-and-add multiply sequencer.
package alu_mul_seq_pkg;

  localparam logic [5:0] ALU_OP_ADD = 6'b000010;
  localparam logic [5:0] ALU_OP_X   = 6'b001100;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_ADD  = 2'd1,
    MUL_DBL  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_alu16.sv
// 16-bit ALU with zx/nx/zy/ny/f/no control, ins[5]=zx .. ins[0]=no.
module alu_mul_seq_alu16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [5:0]  ins,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] x0, x1, y0, y1, f;

  always_comb begin
    x0  = ins[5] ? 16'd0 : x;
    x1  = ins[4] ? ~x0 : x0;
    y0  = ins[3] ? 16'd0 : y;
    y1  = ins[2] ? ~y0 : y0;
    f   = ins[1] ? (x1 + y1) : (x1 & y1);
    out = ins[0] ? ~f : f;
    zr  = (out == 16'd0);
    ng  = out[15];
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 multiplier time-sharing one ALU via ADD/DBL steps.
// Optional ALU_MUL_EARLY_EXIT_EN stops once the remaining multiplier is zero.
module alu_mul_seq
  import alu_mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        zr,
  output logic        ng
);

  mul_state_e  state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mc_q, mc_d;
  logic [15:0] mp_q, mp_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] prod_q, prod_d;
  logic        zr_q, zr_d;
  logic        ng_q, ng_d;
  logic        last;

  logic [15:0] alu_x, alu_y, alu_out;
  logic [5:0]  alu_ins;
  logic        alu_zr, alu_ng;

  alu_mul_seq_alu16 u_alu16 (
    .x   (alu_x),
    .y   (alu_y),
    .ins (alu_ins),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  always_comb begin
    alu_x   = acc_q;
    alu_y   = mc_q;
    alu_ins = ALU_OP_X;
    unique case (state_q)
      MUL_ADD: alu_ins = mp_q[0] ? ALU_OP_ADD : ALU_OP_X;
      MUL_DBL: begin
        alu_x   = mc_q;
        alu_ins = ALU_OP_ADD;
      end
      default: alu_ins = ALU_OP_X;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    last    = 1'b0;
    unique case (state_q)
      MUL_IDLE: begin
        if (start) begin
          acc_d   = 16'd0;
          mc_d    = a;
          mp_d    = b;
          cnt_d   = 4'd0;
          state_d = MUL_ADD;
        end
      end
      MUL_ADD: begin
        if (mp_q[0]) acc_d = alu_out;
        state_d = MUL_DBL;
      end
      MUL_DBL: begin
        mc_d  = alu_out;
        mp_d  = mp_q >> 1;
        cnt_d = cnt_q + 4'd1;
`ifdef ALU_MUL_EARLY_EXIT_EN
        last  = (cnt_q == 4'd15) || (mp_d == 16'd0);
`else
        last  = (cnt_q == 4'd15);
`endif
        state_d = last ? MUL_DONE : MUL_ADD;
      end
      MUL_DONE: begin
        prod_d  = alu_out;
        zr_d    = alu_zr;
        ng_d    = alu_ng;
        state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MUL_IDLE;
      acc_q   <= 16'd0;
      mc_q    <= 16'd0;
      mp_q    <= 16'd0;
      cnt_q   <= 4'd0;
      prod_q  <= 16'd0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
    end
  end

  // The DONE-cycle ALU pass is shown live so the result aligns with done.
  always_comb begin
    busy    = (state_q == MUL_ADD) || (state_q == MUL_DBL);
    done    = (state_q == MUL_DONE);
    product = done ? alu_out : prod_q;
    zr      = done ? alu_zr : zr_q;
    ng      = done ? alu_ng : ng_q;
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: latency, result, flags, ignore and reset.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic        busy, done, zr, ng;
  logic [15:0] product;

  int n_chk = 0;
  int n_ok  = 0;

  alu_mul_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zr      (zr),
    .ng      (ng)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int exp_lat(input logic [15:0] bv);
`ifdef ALU_MUL_EARLY_EXIT_EN
    int hi;
    hi = 0;
    for (int i = 0; i < 16; i++) if (bv[i]) hi = i;
    return 2 * (hi + 1);
`else
    return 32 + 0 * int'(bv[0]);
`endif
  endfunction

  // Accept at E0, then count edges until done; inj>0 re-pulses start at E[inj].
  task automatic run(input string tag, input logic [15:0] av,
                     input logic [15:0] bv, input logic [15:0] pexp,
                     input int inj);
    int n;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, " busy@E0"}, busy, 1);
    for (n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == inj) begin
        start = 1'b1; a = 16'd5; b = 16'd5;
      end else start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk({tag, " done"}, seen, 1);
    chk({tag, " latency"}, n, exp_lat(bv));
    chk({tag, " busy@done"}, busy, 0);
    chk({tag, " product"}, product, pexp);
    chk({tag, " zr"}, zr, pexp == 16'd0);
    chk({tag, " ng"}, ng, pexp[15]);
    @(posedge clk);
    #1;
    chk({tag, " done 1cyc"}, done, 0);
    chk({tag, " hold"}, product, pexp);
  endtask

  initial begin
    int saw;
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst product", product, 0);
    chk("rst zr", zr, 0);
    chk("rst ng", ng, 0);
    rst = 1'b0;

    run("100x3", 16'd100, 16'd3, 16'd300, 0);
    run("ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 0);
    run("256x256", 16'd256, 16'd256, 16'h0000, 0);
    run("-7x6", 16'hFFF9, 16'd6, 16'hFFD6, 0);
    run("ignore", 16'd100, 16'd3, 16'd300, 10);
    run("5x5", 16'd5, 16'd5, 16'd25, 0);
    run("1234x1", 16'd1234, 16'd1, 16'd1234, 0);
    run("1234x0", 16'd1234, 16'd0, 16'd0, 0);

    // Reset mid-run: 100*3 started, reset at E15.
    @(negedge clk);
    a = 16'd100; b = 16'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst product", product, 0);
    chk("midrst zr", zr, 0);
    chk("midrst ng", ng, 0);
    @(negedge clk);
    rst = 1'b0;
    saw = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) saw++;
    end
    chk("midrst no done", saw, 0);
    run("7x9", 16'd7, 16'd9, 16'd63, 0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
